axis_eth_frame_tx: RTL and testbench

//   Ethernet frame transmitter/deparser, the egress counterpart to the ingress parse path.
//   - Accepts one header (dst MAC, src MAC, EtherType) per frame and an AXI4-Stream payload.
//   - Emits a 64-bit AXI4-Stream frame with the 14-byte header prepended.
//   - The payload is byte-realigned by 6 lanes.
//   - No padding and no FCS; a downstream MAC adds both.

---
 rtl/eth_pkg.sv | 27 ++
 rtl/axis_eth_tx_realign.sv | 22 ++
 rtl/axis_eth_frame_tx.sv | 187 ++++++++++++++++++
 tb/tb_axis_eth_frame_tx.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared Ethernet header types and tx state encoding
package eth_pkg;

  localparam int ETH_HDR_BYTES = 14;
  localparam int CARRY_BYTES   = 6;

  typedef logic [47:0] mac_addr_t;
  typedef logic [15:0] ethertype_t;

  typedef struct packed {
    mac_addr_t  dst;
    mac_addr_t  src;
    ethertype_t eth_type;
  } eth_hdr_t;

  typedef enum logic [2:0] {IDLE, HDR1, PAY, TAIL, DONE} tx_state_e;

  // Wire byte 0 of a MAC sits in bits [47:40]; stream lane 0 is bits [7:0].
  function automatic logic [47:0] mac_to_lanes(input mac_addr_t mac);
    logic [47:0] lanes;
    for (int i = 0; i < 6; i++) begin
      lanes[8*i +: 8] = mac[47-8*i -: 8];
    end
    return lanes;
  endfunction

endpackage

// File: rtl/axis_eth_tx_realign.sv
// rtl/axis_eth_tx_realign.sv - merges six carried bytes with a new payload beat
module axis_eth_tx_realign
  import eth_pkg::*;
(
  input  logic [8*CARRY_BYTES-1:0] carry,
  input  logic [63:0]              s_tdata,
  input  logic [7:0]               s_tkeep,
  output logic [63:0]              tdata,
  output logic [7:0]               tkeep,
  output logic                     needs_tail,
  output logic [8*CARRY_BYTES-1:0] next_carry,
  output logic [7:0]               tail_keep
);

  assign tdata      = {s_tdata[15:0], carry};
  assign tkeep      = {s_tkeep[1:0], 6'h3f};
  // More than two bytes in the beat leaves bytes behind for an extra beat.
  assign needs_tail = s_tkeep[2];
  assign next_carry = s_tdata[63:16];
  assign tail_keep  = {2'b00, s_tkeep[7:2]};

endmodule

// File: rtl/axis_eth_frame_tx.sv
// rtl/axis_eth_frame_tx.sv - prepends a 14-byte Ethernet header to an AXI-Stream payload
module axis_eth_frame_tx
  import eth_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int USER_WIDTH = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [47:0]             hdr_dst,
  input  logic [47:0]             hdr_src,
  input  logic [15:0]             hdr_type,
  input  logic                    hdr_valid,
  output logic                    hdr_ready,
  input  logic [DATA_WIDTH-1:0]   s_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_tkeep,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  input  logic                    s_tlast,
  input  logic [USER_WIDTH-1:0]   s_tuser,
  output logic [DATA_WIDTH-1:0]   m_tdata,
  output logic [DATA_WIDTH/8-1:0] m_tkeep,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic                    m_tlast,
  output logic [USER_WIDTH-1:0]   m_tuser
);

  if (DATA_WIDTH != 64) begin : g_bad_width
    $fatal(1, "axis_eth_frame_tx supports DATA_WIDTH=64 only");
  end

  tx_state_e             state_q, state_d;
  logic [47:0]           carry_q, carry_d;
  logic [7:0]            tail_keep_q, tail_keep_d;
  logic [USER_WIDTH-1:0] user_q, user_d;
  logic [63:0]           m_tdata_q, m_tdata_d;
  logic [7:0]            m_tkeep_q, m_tkeep_d;
  logic                  m_tvalid_q, m_tvalid_d;
  logic                  m_tlast_q, m_tlast_d;
  logic [USER_WIDTH-1:0] m_tuser_q, m_tuser_d;

  eth_hdr_t              hdr_in;
  logic [47:0]           dst_lanes, src_lanes;
  logic [63:0]           beat0;
  logic [47:0]           hdr_carry;
  logic                  load;
  logic [USER_WIDTH-1:0] user_acc;

  logic [63:0] rl_tdata;
  logic [7:0]  rl_tkeep, rl_tail_keep;
  logic        rl_needs_tail;
  logic [47:0] rl_next_carry;

  assign hdr_in    = {hdr_dst, hdr_src, hdr_type};
  assign dst_lanes = mac_to_lanes(hdr_in.dst);
  assign src_lanes = mac_to_lanes(hdr_in.src);
  assign beat0     = {src_lanes[15:0], dst_lanes};
  // Header bytes 8..13 are preloaded as carry so HDR1 merges exactly like PAY.
  assign hdr_carry = {hdr_in.eth_type[7:0], hdr_in.eth_type[15:8], src_lanes[47:16]};
  assign load      = !m_tvalid_q || m_tready;
  assign user_acc  = user_q | s_tuser;

  axis_eth_tx_realign u_realign (
    .carry      (carry_q),
    .s_tdata    (s_tdata),
    .s_tkeep    (s_tkeep),
    .tdata      (rl_tdata),
    .tkeep      (rl_tkeep),
    .needs_tail (rl_needs_tail),
    .next_carry (rl_next_carry),
    .tail_keep  (rl_tail_keep)
  );

  always_comb begin
    state_d     = state_q;
    carry_d     = carry_q;
    tail_keep_d = tail_keep_q;
    user_d      = user_q;
    m_tdata_d   = m_tdata_q;
    m_tkeep_d   = m_tkeep_q;
    m_tvalid_d  = m_tvalid_q;
    m_tlast_d   = m_tlast_q;
    m_tuser_d   = m_tuser_q;
    hdr_ready   = 1'b0;
    s_tready    = 1'b0;
    if (load) begin
      m_tvalid_d = 1'b0;
      m_tlast_d  = 1'b0;
      m_tuser_d  = '0;
    end
    unique case (state_q)
      IDLE: begin
        hdr_ready = rst_n && load;
        if (hdr_valid && load) begin
          m_tdata_d  = beat0;
          m_tkeep_d  = 8'hff;
          m_tvalid_d = 1'b1;
          carry_d    = hdr_carry;
          user_d     = '0;
          state_d    = HDR1;
        end
      end
      HDR1, PAY: begin
        s_tready = load;
        if (s_tvalid && load) begin
          m_tdata_d  = rl_tdata;
          m_tkeep_d  = 8'hff;
          m_tvalid_d = 1'b1;
          carry_d    = rl_next_carry;
          user_d     = user_acc;
          state_d    = PAY;
          if (s_tlast && rl_needs_tail) begin
            tail_keep_d = rl_tail_keep;
            state_d     = TAIL;
          end else if (s_tlast) begin
            m_tkeep_d = rl_tkeep;
            m_tlast_d = 1'b1;
            m_tuser_d = user_acc;
            user_d    = '0;
            state_d   = DONE;
          end
        end
      end
      TAIL: begin
        if (load) begin
          m_tdata_d  = {16'h0000, carry_q};
          m_tkeep_d  = tail_keep_q;
          m_tvalid_d = 1'b1;
          m_tlast_d  = 1'b1;
          m_tuser_d  = user_q;
          user_d     = '0;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (m_tvalid_q && m_tready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      carry_q     <= '0;
      tail_keep_q <= '0;
      user_q      <= '0;
      m_tdata_q   <= '0;
      m_tkeep_q   <= '0;
      m_tvalid_q  <= 1'b0;
      m_tlast_q   <= 1'b0;
      m_tuser_q   <= '0;
    end else begin
      state_q     <= state_d;
      carry_q     <= carry_d;
      tail_keep_q <= tail_keep_d;
      user_q      <= user_d;
      m_tdata_q   <= m_tdata_d;
      m_tkeep_q   <= m_tkeep_d;
      m_tvalid_q  <= m_tvalid_d;
      m_tlast_q   <= m_tlast_d;
      m_tuser_q   <= m_tuser_d;
    end
  end

  assign m_tdata  = m_tdata_q;
  assign m_tkeep  = m_tkeep_q;
  assign m_tvalid = m_tvalid_q;
  assign m_tlast  = m_tlast_q;
  assign m_tuser  = m_tuser_q;

`ifndef SYNTHESIS
  logic [7:0] keep_inc;
  assign keep_inc = s_tkeep + 8'd1;

  a_keep_contig: assert property (@(posedge clk) disable iff (!rst_n)
    s_tvalid |-> ((s_tkeep & keep_inc) == 8'd0));

  a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (m_tvalid && !m_tready) |=> (m_tvalid && $stable(m_tdata) && $stable(m_tkeep)
                                 && $stable(m_tlast) && $stable(m_tuser)));
`endif

endmodule

// File: tb/tb_axis_eth_frame_tx.sv
// tb/tb_axis_eth_frame_tx.sv - randomized scoreboard bench for axis_eth_frame_tx
module tb_axis_eth_frame_tx;

  localparam int UW   = 1;
  localparam int MAXF = 40;
  localparam int MAXB = 96;
  localparam int MAXW = 400;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [47:0]   hdr_dst = '0, hdr_src = '0;
  logic [15:0]   hdr_type = '0;
  logic          hdr_valid = 1'b0, hdr_ready;
  logic [63:0]   s_tdata = '0;
  logic [7:0]    s_tkeep = '0;
  logic          s_tvalid = 1'b0, s_tready, s_tlast = 1'b0;
  logic [UW-1:0] s_tuser = '0;
  logic [63:0]   m_tdata;
  logic [7:0]    m_tkeep;
  logic          m_tvalid, m_tready = 1'b1, m_tlast;
  logic [UW-1:0] m_tuser;

  always #5 clk = ~clk;

  axis_eth_frame_tx #(.DATA_WIDTH(64), .USER_WIDTH(UW)) dut (
    .clk(clk), .rst_n(rst_n),
    .hdr_dst(hdr_dst), .hdr_src(hdr_src), .hdr_type(hdr_type),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_tlast(s_tlast), .s_tuser(s_tuser),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast), .m_tuser(m_tuser)
  );

  int total = 0;
  int passed = 0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic finish_run();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  endtask

  task automatic timeout(input string what);
    total++;
    $display("FAIL timeout %s: got no handshake expected one within %0d cycles", what, MAXW);
    finish_run();
  endtask

  typedef struct {
    logic [63:0]   data;
    logic [7:0]    keep;
    logic          last;
    logic [UW-1:0] user;
  } beat_t;
  beat_t exp_q[$];

  logic [47:0]   f_dst [MAXF];
  logic [47:0]   f_src [MAXF];
  logic [15:0]   f_type[MAXF];
  int            f_len [MAXF];
  logic [7:0]    f_pay [MAXF][MAXB];
  logic [UW-1:0] f_usr [MAXF][MAXB/8];
  bit            accepted[MAXF];
  int            nfr = 0;
  int            tr_mode = 0;

  task automatic new_frame(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] typ, input int len);
    f_dst[nfr] = dst; f_src[nfr] = src; f_type[nfr] = typ; f_len[nfr] = len;
    for (int i = 0; i < MAXB; i++) f_pay[nfr][i] = 8'($urandom);
    for (int i = 0; i < MAXB/8; i++) f_usr[nfr][i] = '0;
    accepted[nfr] = 1'b0;
    nfr++;
  endtask

  // Reference: the frame is the 14 header bytes followed by the payload bytes, cut into 8-byte beats.
  function automatic void push_expected(input int f);
    logic [7:0]    bytes[$];
    logic [UW-1:0] uo;
    int            nb;
    beat_t         e;
    for (int k = 0; k < 6; k++) bytes.push_back(f_dst[f][47-8*k -: 8]);
    for (int k = 0; k < 6; k++) bytes.push_back(f_src[f][47-8*k -: 8]);
    bytes.push_back(f_type[f][15:8]);
    bytes.push_back(f_type[f][7:0]);
    for (int i = 0; i < f_len[f]; i++) bytes.push_back(f_pay[f][i]);
    uo = '0;
    for (int b = 0; b < (f_len[f] + 7) / 8; b++) uo |= f_usr[f][b];
    nb = (bytes.size() + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      e.data = '0; e.keep = '0;
      for (int l = 0; l < 8; l++) begin
        if (b*8 + l < bytes.size()) begin
          e.data[8*l +: 8] = bytes[b*8 + l];
          e.keep[l] = 1'b1;
        end
      end
      e.last = (b == nb - 1);
      e.user = e.last ? uo : '0;
      exp_q.push_back(e);
    end
  endfunction

  always @(negedge clk) begin
    case (tr_mode)
      0:       m_tready <= 1'b1;
      1:       m_tready <= ~m_tready;
      default: m_tready <= 1'($urandom_range(0, 1));
    endcase
  end

  task automatic check_zero(input string tag);
    chk(m_tvalid == 1'b0, {tag, "_m_tvalid"}, 64'(m_tvalid), 0);
    chk(m_tdata == 64'h0, {tag, "_m_tdata"}, m_tdata, 0);
    chk(m_tkeep == 8'h0, {tag, "_m_tkeep"}, 64'(m_tkeep), 0);
    chk(m_tlast == 1'b0, {tag, "_m_tlast"}, 64'(m_tlast), 0);
    chk(m_tuser == '0, {tag, "_m_tuser"}, 64'(m_tuser), 0);
    chk(s_tready == 1'b0, {tag, "_s_tready"}, 64'(s_tready), 0);
    chk(hdr_ready == 1'b0, {tag, "_hdr_ready"}, 64'(hdr_ready), 0);
  endtask

  // Monitor: samples 1ns before each rising edge.
  int            cyc = 0;
  int            tl_cyc = 0;
  bit            pend_rise = 1'b0;
  bit            prev_stall = 1'b0;
  logic [63:0]   pd;
  logic [7:0]    pk;
  logic          pl;
  logic [UW-1:0] pu;

  initial begin
    beat_t e;
    logic [63:0] mask;
    forever begin
      @(negedge clk);
      #4;
      cyc++;
      if (!rst_n) begin
        prev_stall = 1'b0;
        pend_rise = 1'b0;
        continue;
      end
      if (prev_stall)
        chk(m_tvalid && m_tdata == pd && m_tkeep == pk && m_tlast == pl && m_tuser == pu,
            "stall_hold", m_tdata, pd);
      prev_stall = m_tvalid && !m_tready;
      pd = m_tdata; pk = m_tkeep; pl = m_tlast; pu = m_tuser;
      if (hdr_ready && pend_rise) begin
        chk(cyc == tl_cyc + 1, "hdr_ready_rise_cycle", 64'(cyc), 64'(tl_cyc + 1));
        pend_rise = 1'b0;
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_beat", m_tdata, 0);
        end else begin
          e = exp_q.pop_front();
          mask = '0;
          for (int l = 0; l < 8; l++) if (e.keep[l]) mask[8*l +: 8] = 8'hff;
          chk((m_tdata & mask) == e.data, "beat_data", m_tdata & mask, e.data);
          chk(m_tkeep == e.keep, "beat_keep", 64'(m_tkeep), 64'(e.keep));
          chk(m_tlast == e.last, "beat_last", 64'(m_tlast), 64'(e.last));
          chk(m_tuser == e.user, "beat_user", 64'(m_tuser), 64'(e.user));
        end
        if (m_tlast) begin
          tl_cyc = cyc;
          pend_rise = 1'b1;
        end
      end
    end
  end

  task automatic do_reset_mid_frame();
    @(negedge clk);
    rst_n = 1'b0;
    s_tvalid = 1'b0;
    hdr_valid = 1'b0;
    #1;
    check_zero("midreset");
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_batch(input int a, input int b, input int abort_f, input int abort_b);
    fork
      begin : hdr_proc
        int w;
        for (int f = a; f <= b; f++) begin
          @(negedge clk);
          hdr_dst = f_dst[f]; hdr_src = f_src[f]; hdr_type = f_type[f];
          hdr_valid = 1'b1;
          w = 0;
          forever begin
            #4;
            if (hdr_ready) break;
            if (++w > MAXW) timeout("hdr");
            @(negedge clk);
          end
          push_expected(f);
          accepted[f] = 1'b1;
        end
        @(negedge clk);
        hdr_valid = 1'b0;
      end
      begin : pay_proc
        int w, nb, cnt;
        bit aborted;
        aborted = 1'b0;
        for (int f = a; f <= b && !aborted; f++) begin
          @(negedge clk);
          s_tvalid = 1'b0;
          w = 0;
          while (!accepted[f]) begin
            if (++w > MAXW) timeout("hdr_accept");
            @(negedge clk);
          end
          nb = (f_len[f] + 7) / 8;
          for (int bt = 0; bt < nb; bt++) begin
            if (bt > 0) @(negedge clk);
            cnt = (f_len[f] - bt*8 > 8) ? 8 : f_len[f] - bt*8;
            s_tdata = {$urandom, $urandom};
            s_tkeep = '0;
            for (int l = 0; l < cnt; l++) begin
              s_tdata[8*l +: 8] = f_pay[f][bt*8 + l];
              s_tkeep[l] = 1'b1;
            end
            s_tlast = (bt == nb - 1);
            s_tuser = f_usr[f][bt];
            s_tvalid = 1'b1;
            w = 0;
            forever begin
              #4;
              if (s_tready) break;
              if (++w > MAXW) timeout("payload");
              @(negedge clk);
            end
            if (f == abort_f && bt == abort_b) begin
              do_reset_mid_frame();
              aborted = 1'b1;
              break;
            end
          end
        end
        @(negedge clk);
        s_tvalid = 1'b0;
      end
    join
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < MAXW) begin
      @(negedge clk);
      w++;
    end
    repeat (3) @(negedge clk);
    chk(exp_q.size() == 0, "drain_queue_empty", 64'(exp_q.size()), 0);
  endtask

  localparam logic [47:0] T1_DST  = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] T1_SRC  = 48'h0011_2233_4455;
  localparam logic [15:0] T1_TYPE = 16'h0800;

  initial begin
    #500_000;
    total++;
    $display("FAIL watchdog: got no end of run expected finish before 500us");
    finish_run();
  end

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    new_frame(T1_DST, T1_SRC, T1_TYPE, 8);
    for (int i = 0; i < 8; i++) f_pay[0][i] = 8'(i + 1);
    tr_mode = 0;
    run_batch(0, 0, -1, -1);
    drain();

    new_frame(T1_DST, T1_SRC, T1_TYPE, 2);
    f_pay[1][0] = 8'hAA; f_pay[1][1] = 8'hBB;
    run_batch(1, 1, -1, -1);
    drain();

    new_frame(T1_DST, T1_SRC, T1_TYPE, 64);
    for (int i = 0; i < 64; i++) f_pay[2][i] = 8'(i);
    tr_mode = 1;
    run_batch(2, 2, -1, -1);
    drain();

    tr_mode = 0;
    new_frame({$urandom, 16'h1234}, {$urandom, 16'h5678}, 16'h86DD, 20);
    new_frame({$urandom, 16'h9abc}, {$urandom, 16'hdef0}, 16'h0806, 13);
    run_batch(3, 4, -1, -1);
    drain();

    tr_mode = 2;
    new_frame(T1_DST, T1_SRC, T1_TYPE, 32);
    f_usr[5][1] = 1'b1;
    new_frame(T1_SRC, T1_DST, 16'h88B5, 27);
    run_batch(5, 6, -1, -1);
    drain();

    tr_mode = 0;
    new_frame(T1_DST, T1_SRC, T1_TYPE, 40);
    run_batch(7, 7, 7, 2);
    drain();
    new_frame(T1_DST, T1_SRC, T1_TYPE, 8);
    for (int i = 0; i < 8; i++) f_pay[8][i] = 8'(i + 1);
    run_batch(8, 8, -1, -1);
    drain();

    tr_mode = 2;
    new_frame({$urandom, 16'h0001}, {$urandom, 16'h0002}, 16'h0800, 1);
    for (int f = 10; f < 30; f++) begin
      new_frame({$urandom, 16'($urandom)}, {$urandom, 16'($urandom)}, 16'($urandom), int'($urandom_range(1, 80)));
      for (int b = 0; b < 10; b++) f_usr[f][b] = ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0;
    end
    run_batch(9, 29, -1, -1);
    drain();

    finish_run();
  end

endmodule
